color_freq_meter: RTL and testbench
===================================

# color_freq_meter

Upstream measurement stage for the rover's colour sensor path. It drives the TCS3200-style sensor's scale, filter-select and output-enable pins, counts rising edges of the sensor's square-wave output over a fixed gate window per photodiode filter, and publishes one count per channel. The downstream colour classifier consumes these counts as its frequency input. Operation is free-running whenever enabled.

## Interface
Parameters:
- GATE_CYCLES, 50000: clocks per counting window (1 ms at 50 MHz).
- SETTLE_CYCLES, 5000: clocks waited after each filter change before counting.
- CNT_W, 16: width of each channel count.
- SCALE, 2'b11: constant driven on `scale` (11 = 100 %).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run measurement frames while high.
- freq_in  input  1  sensor output, asynchronous to clk.
- scale  output  2  sensor S0/S1, constant SCALE.
- filter  output  2  sensor S2/S3: red 00, blue 01, clear 10, green 11.
- oe_n  output  1  sensor output-enable, active low.
- red_cnt, green_cnt, blue_cnt, clear_cnt  output  CNT_W each  latched counts of the last complete frame.
- overflow  output  1  a count in the last frame saturated.
- frame_valid  output  1  one-cycle pulse when the count outputs update.

## Operation
- freq_in passes through a 2-flop synchroniser, then a rising-edge detector (sync[1] & ~prev).
- FSM states: IDLE, SETTLE, GATE.
  - IDLE: oe_n=1, filter=00. If enable=1, go to SETTLE with the channel index set to the first channel.
  - SETTLE: drive the channel's filter code. Timer loads SETTLE_CYCLES-1 and counts down. When it reaches 0, go to GATE, clear the edge counter and load the timer with GATE_CYCLES-1.
  - GATE: each detected edge increments the edge counter. At timer 0, that cycle's edge is still counted, then the count is stored in the channel's shadow register. If more channels remain, advance the index and go to SETTLE.
  - Last channel: copy all shadow registers and the frame overflow flag to the outputs, then go to SETTLE on the first channel (enable=1) or to IDLE.
- Channel order: red, green, blue, clear.
- The edge counter saturates at 2^CNT_W-1, and saturation sets the frame overflow flag. The flag clears at frame start.
- enable=0 in SETTLE or GATE: go to IDLE on the next clock. The partial frame is discarded and the outputs hold the last complete frame.
- oe_n=0 in SETTLE and GATE.

## Timing
- Reset values: scale=SCALE, filter=00, oe_n=1, all counts 0, overflow=0, frame_valid=0, state IDLE.
- Edge-to-count latency: 3 clocks (2 for the synchroniser, 1 for the detector/increment).
- Per-channel time: SETTLE_CYCLES + GATE_CYCLES clocks.
- Frame period: N*(SETTLE_CYCLES+GATE_CYCLES) clocks, N = channel count. The first frame starts 1 clock after enable rises in IDLE.
- Output update: count outputs, overflow and the frame_valid pulse all become visible together, on the clock after the last channel's final GATE cycle.
- Reset asserted mid-frame: immediate return to the reset values.
- Measurable frequency: freq_in must stay below clk/4; faster inputs are undercounted.

## Configuration
- COLOR_FREQ_CLEAR_EN defined:
  - 4-channel frame including clear (filter 10).
  - clear_cnt is live.
- Undefined:
  - 3-channel frame (red, green, blue).
  - clear_cnt is tied to 0.
  - Frame period is 3*(SETTLE_CYCLES+GATE_CYCLES).

## Structure
- Shared package color_pkg holds:
  - filter codes FILT_RED, FILT_BLUE, FILT_CLEAR, FILT_GREEN;
  - the channel-index enum;
  - the FSM state enum, also used by the downstream classifier for filter decoding.
- One natural sub-module: edge_sync_counter, containing the synchroniser, edge detect and saturating counter, with clear and enable inputs.

## Test plan
- 100 kHz freq_in at 50 MHz clk, GATE_CYCLES=50000, SETTLE_CYCLES=100, enable=1 → red/green/blue/clear each 100±1, overflow=0, frame_valid pulse every 4×50100 clocks (3× without the macro).
- Different frequency per filter code (R 20 kHz, G 40 kHz, B 60 kHz, C 120 kHz) → counts 20/40/60/120 ±1 in the matching registers.
- CNT_W=4 with a 1 MHz input → affected count = 15, overflow=1. Next frame at 5 kHz → overflow=0.
- enable dropped mid-GATE of green → IDLE next clock, oe_n=1, no frame_valid, outputs keep the previous frame.
- rst_n pulsed low mid-frame → all outputs return to reset values asynchronously. The first new frame_valid arrives a full frame period after release with enable=1.
- Edges on freq_in during SETTLE only → all counts 0.

Source files
------------

// File: rtl/color_pkg.sv
// -----------------------------------------------------------------------------
// color_pkg
// Shared definitions for the colour sensor path: TCS3200 filter-select codes,
// the channel-index enum, the measurement FSM state enum and the channel count.
// Used by color_freq_meter and by the downstream colour classifier.
//
// Build option: COLOR_FREQ_CLEAR_EN adds the clear (unfiltered) photodiode
// as a fourth channel. Without it a frame measures red, green and blue only.
// -----------------------------------------------------------------------------
package color_pkg;

    // Sensor S2/S3 filter-select codes
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;
    localparam logic [1:0] FILT_GREEN = 2'b11;

    // Channel index, in measurement order
    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2,
        CH_CLEAR = 2'd3
    } chan_e;

    // Measurement FSM state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2
    } state_e;

`ifdef COLOR_FREQ_CLEAR_EN
    localparam int    NUM_CH  = 4;
    localparam chan_e CH_LAST = CH_CLEAR;
`else
    localparam int    NUM_CH  = 3;
    localparam chan_e CH_LAST = CH_BLUE;
`endif

    // Filter code to drive while measuring a channel
    function automatic logic [1:0] chan_filter(input chan_e ch);
        logic [1:0] code;
        case (ch)
            CH_RED:   code = FILT_RED;
            CH_GREEN: code = FILT_GREEN;
            CH_BLUE:  code = FILT_BLUE;
            default:  code = FILT_CLEAR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/color_freq_meter_edge_sync_counter.sv
// -----------------------------------------------------------------------------
// edge_sync_counter
// Brings the asynchronous sensor square wave into the clk domain with a
// 2-flop synchroniser, detects rising edges and counts them in a saturating
// counter.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   freq_in     : sensor output, asynchronous to clk
//   clear       : hold the counter at zero (has priority over en)
//   en          : count detected edges while high
//   count_next  : counter value after this cycle's update (includes the
//                 edge detected in the current cycle)
//   saturated   : count_next is at full scale while counting is enabled
// -----------------------------------------------------------------------------
module edge_sync_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freq_in,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count_next,
    output logic             saturated
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             edge_det;

    always_comb begin
        sync_d   = {sync_q[0], freq_in};
        prev_d   = sync_q[1];
        edge_det = sync_q[1] & ~prev_q;
        count_d  = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && edge_det && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
        count_next = count_d;
        saturated  = en && (count_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/color_freq_meter.sv
// -----------------------------------------------------------------------------
// color_freq_meter
// Drives a TCS3200-style colour sensor and measures the output frequency of
// each photodiode filter by counting rising edges over a fixed gate window.
// A frame walks red, green, blue (and clear when COLOR_FREQ_CLEAR_EN is
// defined); each channel gets SETTLE_CYCLES of settling after the filter
// change, then GATE_CYCLES of counting. Completed frames are published all at
// once with a one-cycle frame_valid pulse. Dropping enable abandons the
// partial frame; the outputs keep the last complete frame.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : run measurement frames while high
//   freq_in        : sensor output, asynchronous to clk
//   scale          : sensor S0/S1, constant SCALE
//   filter         : sensor S2/S3 filter select
//   oe_n           : sensor output enable, active low
//   red_cnt, green_cnt, blue_cnt, clear_cnt : counts of the last frame
//                    (clear_cnt is 0 without COLOR_FREQ_CLEAR_EN)
//   overflow       : some count of the last frame saturated
//   frame_valid    : one-cycle pulse when the count outputs update
// -----------------------------------------------------------------------------
module color_freq_meter
    import color_pkg::*;
#(
    parameter int         GATE_CYCLES   = 50000,
    parameter int         SETTLE_CYCLES = 5000,
    parameter int         CNT_W         = 16,
    parameter logic [1:0] SCALE         = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             freq_in,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic             oe_n,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             overflow,
    output logic             frame_valid
);

    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LOAD   = 32'(GATE_CYCLES - 1);

    state_e           state_q, state_d;
    chan_e            chan_q, chan_d;
    logic [31:0]      timer_q, timer_d;
    logic [1:0]       filter_q, filter_d;
    logic             oe_n_q, oe_n_d;
    logic             frame_ovf_q, frame_ovf_d;
    logic             overflow_q, overflow_d;
    logic             frame_valid_q, frame_valid_d;
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W-1:0] shadow_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];

    logic [CNT_W-1:0] count_next;
    logic             cnt_sat;

    // Counter is held clear outside GATE, so it starts every window at zero.
    edge_sync_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .freq_in    (freq_in),
        .clear      (state_q != ST_GATE),
        .en         (state_q == ST_GATE),
        .count_next (count_next),
        .saturated  (cnt_sat)
    );

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        timer_d       = timer_q;
        filter_d      = filter_q;
        oe_n_d        = oe_n_q;
        frame_ovf_d   = frame_ovf_q;
        overflow_d    = overflow_q;
        frame_valid_d = 1'b0;
        shadow_d      = shadow_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                oe_n_d   = 1'b1;
                filter_d = FILT_RED;
                if (enable) begin
                    state_d     = ST_SETTLE;
                    chan_d      = CH_RED;
                    timer_d     = SETTLE_LOAD;
                    filter_d    = chan_filter(CH_RED);
                    oe_n_d      = 1'b0;
                    frame_ovf_d = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    oe_n_d   = 1'b1;
                    filter_d = FILT_RED;
                end else if (timer_q == '0) begin
                    state_d = ST_GATE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_GATE: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    oe_n_d   = 1'b1;
                    filter_d = FILT_RED;
                end else begin
                    frame_ovf_d = frame_ovf_q | cnt_sat;
                    if (timer_q == '0) begin
                        // count_next already includes this cycle's edge
                        shadow_d[chan_q] = count_next;
                        state_d          = ST_SETTLE;
                        timer_d          = SETTLE_LOAD;
                        if (chan_q == CH_LAST) begin
                            cnt_d         = shadow_d;
                            overflow_d    = frame_ovf_q | cnt_sat;
                            frame_valid_d = 1'b1;
                            frame_ovf_d   = 1'b0;
                            chan_d        = CH_RED;
                            filter_d      = chan_filter(CH_RED);
                        end else begin
                            chan_d   = chan_e'(chan_q + 2'd1);
                            filter_d = chan_filter(chan_e'(chan_q + 2'd1));
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                oe_n_d   = 1'b1;
                filter_d = FILT_RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            chan_q        <= CH_RED;
            timer_q       <= '0;
            filter_q      <= FILT_RED;
            oe_n_q        <= 1'b1;
            frame_ovf_q   <= 1'b0;
            overflow_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            timer_q       <= timer_d;
            filter_q      <= filter_d;
            oe_n_q        <= oe_n_d;
            frame_ovf_q   <= frame_ovf_d;
            overflow_q    <= overflow_d;
            frame_valid_q <= frame_valid_d;
            shadow_q      <= shadow_d;
            cnt_q         <= cnt_d;
        end
    end

    assign scale       = SCALE;
    assign filter      = filter_q;
    assign oe_n        = oe_n_q;
    assign overflow    = overflow_q;
    assign frame_valid = frame_valid_q;
    assign red_cnt     = cnt_q[CH_RED];
    assign green_cnt   = cnt_q[CH_GREEN];
    assign blue_cnt    = cnt_q[CH_BLUE];
`ifdef COLOR_FREQ_CLEAR_EN
    assign clear_cnt   = cnt_q[CH_CLEAR];
`else
    assign clear_cnt   = '0;
`endif

endmodule

// File: tb/tb_color_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_color_freq_meter
// Directed bench for color_freq_meter with a short gate (100 clocks), short
// settle (10 clocks) and 4-bit counts. The sensor model produces a square wave
// whose period depends on the filter currently selected by the DUT; periods
// divide the gate length, so each window sees an exact number of edges.
// -----------------------------------------------------------------------------
module tb_color_freq_meter;

    localparam int GATE   = 100;
    localparam int SETTLE = 10;
    localparam int CW     = 4;
`ifdef COLOR_FREQ_CLEAR_EN
    localparam int NCH       = 4;
    localparam int EXP_CLEAR = 2;
`else
    localparam int NCH       = 3;
    localparam int EXP_CLEAR = 0;
`endif
    localparam int FRAME = NCH * (SETTLE + GATE);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          freq_in = 1'b0;
    logic [1:0]    scale;
    logic [1:0]    filter;
    logic          oe_n;
    logic [CW-1:0] red_cnt, green_cnt, blue_cnt, clear_cnt;
    logic          overflow;
    logic          frame_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // sensor model controls
    int p_red = 10, p_green = 20, p_blue = 25, p_clear = 50;
    int mode = 0;           // 0: periodic per filter, 1: pulses only right after a filter change
    int cyc = 0;
    int since_chg = 0;
    logic [1:0] last_filt = 2'b00;

    color_freq_meter #(
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CW),
        .SCALE         (2'b11)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .freq_in     (freq_in),
        .scale       (scale),
        .filter      (filter),
        .oe_n        (oe_n),
        .red_cnt     (red_cnt),
        .green_cnt   (green_cnt),
        .blue_cnt    (blue_cnt),
        .clear_cnt   (clear_cnt),
        .overflow    (overflow),
        .frame_valid (frame_valid)
    );

    // clock
    initial forever #5 clk = ~clk;

    // sensor model, updated away from the active edge
    initial begin
        int p;
        forever begin
            @(negedge clk);
            cyc++;
            if (filter !== last_filt) begin
                since_chg = 0;
                last_filt = filter;
            end else begin
                since_chg++;
            end
            case (filter)
                2'b00:   p = p_red;
                2'b11:   p = p_green;
                2'b01:   p = p_blue;
                default: p = p_clear;
            endcase
            if (mode == 0) freq_in = ((cyc % p) < (p / 2));
            else           freq_in = (since_chg == 1) || (since_chg == 3);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for frame_valid, sampling 1 time unit after each rising edge.
    // n returns the number of edges seen up to and including the pulse.
    task automatic wait_fv(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_valid) return;
        end
        check("frame_valid_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int fv_seen;

        // reset state
        #12;
        check("rst_scale", scale, 3);
        check("rst_filter", filter, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_red", red_cnt, 0);
        check("rst_green", green_cnt, 0);
        check("rst_blue", blue_cnt, 0);
        check("rst_clear", clear_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fv", frame_valid, 0);

        // first frame, distinct period per filter
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_oe_n", oe_n, 1);
        enable = 1'b1;
        wait_fv(FRAME + 50, n);
        check("first_frame_latency", n, FRAME + 1);
        check("f1_red", red_cnt, 10);
        check("f1_green", green_cnt, 5);
        check("f1_blue", blue_cnt, 4);
        check("f1_clear", clear_cnt, EXP_CLEAR);
        check("f1_overflow", overflow, 0);

        // pulse width and sensor pins at frame start
        @(posedge clk); #1;
        check("fv_one_cycle", frame_valid, 0);
        check("red_filter", filter, 2'b00);
        check("red_oe_n", oe_n, 0);
        repeat (114) @(posedge clk);
        #1;
        check("green_filter", filter, 2'b11);
        p_red = 4;  // red saturates next frame (25 edges into 4 bits)
        wait_fv(FRAME, n);
        check("frame_period_part", n, FRAME - 115);
        check("f2_red", red_cnt, 10);

        // saturation frame
        wait_fv(FRAME + 50, n);
        check("frame_period", n, FRAME);
        check("f3_red_sat", red_cnt, 15);
        check("f3_green", green_cnt, 5);
        check("f3_blue", blue_cnt, 4);
        check("f3_overflow", overflow, 1);

        // overflow clears on the following clean frame
        p_red = 10;
        wait_fv(FRAME + 50, n);
        check("f4_red", red_cnt, 10);
        check("f4_overflow", overflow, 0);

        // enable dropped during green gate
        repeat (160) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("drop_oe_n", oe_n, 1);
        check("drop_filter", filter, 0);
        fv_seen = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (frame_valid) fv_seen++;
        end
        check("drop_no_fv", fv_seen, 0);
        check("drop_red_hold", red_cnt, 10);
        check("drop_green_hold", green_cnt, 5);
        check("drop_blue_hold", blue_cnt, 4);
        check("drop_oe_n_hold", oe_n, 1);

        // asynchronous reset mid-frame
        enable = 1'b1;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_red", red_cnt, 0);
        check("mid_rst_green", green_cnt, 0);
        check("mid_rst_blue", blue_cnt, 0);
        check("mid_rst_oe_n", oe_n, 1);
        check("mid_rst_filter", filter, 0);
        check("mid_rst_fv", frame_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fv(FRAME + 50, n);
        check("post_rst_latency", n, FRAME + 1);
        check("post_rst_red", red_cnt, 10);
        check("post_rst_blue", blue_cnt, 4);

        // edges only while settling are never counted
        mode = 1;
        wait_fv(FRAME + 50, n);
        check("settle_red", red_cnt, 0);
        check("settle_green", green_cnt, 0);
        check("settle_blue", blue_cnt, 0);
        check("settle_clear", clear_cnt, 0);
        check("settle_overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
